// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST: status encoding, FSM states,
// LFSR feedback taps and the sum classifier used by both checker and model.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_MAX   = 2'b01,
    ST_OTHER = 2'b10
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fibonacci taps for a left-shifting LFSR; bit k set means stage k+1 feeds back.
  localparam logic [63:0] LFSR_TAPS_8 = 64'h0000_0000_0000_00B8;

  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       return 64'h0000_0000_0000_0006;
      4:       return 64'h0000_0000_0000_000C;
      5:       return 64'h0000_0000_0000_0014;
      6:       return 64'h0000_0000_0000_0030;
      7:       return 64'h0000_0000_0000_0060;
      8:       return LFSR_TAPS_8;
      16:      return 64'h0000_0000_0000_D008;
      default: return 64'h3 << (width - 2);
    endcase
  endfunction

  function automatic status_t classify(input logic [63:0] sum, input int unsigned width);
    logic [63:0] mask;
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    if (sum == 64'd0)       return ST_ZERO;
    else if (sum == mask)   return ST_MAX;
    else                    return ST_OTHER;
  endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// Operand-b pattern generator: left-shifting Fibonacci LFSR with a
// never-zero seed, reloaded at the start of each run.
module adder_bist_lfsr
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic [31:0] SEED  = 32'h0000_00A5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] r_value;
  logic             w_feedback;

  assign w_feedback = ^(r_value & TAPS);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_value <= SEED_INIT;
    end else if (advance) begin
      r_value <= {r_value[WIDTH-2:0], w_feedback};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/adder_bist.sv
// BIST initiator/checker for the registered adder: issues one vector per
// cycle and checks the adder's answer one cycle after the operands were presented.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h0000_00A5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [1:0]       status_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [15:0]      LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           r_state, w_next_state;
  logic             w_start, w_issue, w_advance, w_mismatch;
  logic [15:0]      w_vec_idx;
  logic [WIDTH-1:0] w_vec_a, w_vec_b, w_lfsr, w_sum;

  logic [15:0]      r_idx, r_chk_idx, r_err_count, r_first_err_idx;
  logic [WIDTH-1:0] r_a, r_b, r_exp_sum;
  status_t          r_exp_status;
  logic             r_chk_valid, r_pass;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_start      = 1'b1;
          w_issue      = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) w_next_state = DRAIN;
        else                   w_issue      = 1'b1;
      end
      DRAIN:   w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Vector i sits on a_o/b_o for the whole RUN cycle with r_idx == i.
  always_comb begin
    w_vec_idx = w_start ? 16'd0 : r_idx + 16'd1;
    w_vec_a   = WIDTH'(w_vec_idx);
    w_vec_b   = w_lfsr;
    case (w_vec_idx)
      16'd0: begin w_vec_a = '0;       w_vec_b = '0;        end
      16'd1: begin w_vec_a = ALL_ONES; w_vec_b = '0;        end
      16'd2: begin w_vec_a = ALL_ONES; w_vec_b = WIDTH'(1); end
      default: ;
    endcase
    w_advance = w_issue && (w_vec_idx >= 16'd3);
  end

  adder_bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_start),
    .advance (w_advance),
    .value   (w_lfsr)
  );

  assign w_sum      = r_a + r_b;
  assign w_mismatch = r_chk_valid &&
                      ((sum_i != r_exp_sum) || (status_i != r_exp_status));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a             <= '0;
      r_b             <= '0;
      r_idx           <= '0;
      r_exp_sum       <= '0;
      r_exp_status    <= ST_ZERO;
      r_chk_idx       <= '0;
      r_chk_valid     <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
    end else begin
      // Expectation trails the operands by one cycle to line up with the adder register.
      r_chk_valid  <= (r_state == RUN);
      r_exp_sum    <= w_sum;
      r_exp_status <= classify(64'(w_sum), WIDTH);
      r_chk_idx    <= r_idx;
      if (w_issue) begin
        r_a   <= w_vec_a;
        r_b   <= w_vec_b;
        r_idx <= w_vec_idx;
      end else begin
        r_a <= '0;
        r_b <= '0;
      end
      if (w_start) begin
        r_err_count     <= '0;
        r_first_err_idx <= '0;
        r_pass          <= 1'b0;
      end else begin
        if (w_mismatch) begin
          if (r_err_count == 16'd0)     r_first_err_idx <= r_chk_idx;
          if (r_err_count != 16'hFFFF)  r_err_count     <= r_err_count + 16'd1;
        end
        if (r_state == DRAIN) r_pass <= (r_err_count == 16'd0) && !w_mismatch;
      end
    end
  end

  assign a_o           = r_a;
  assign b_o           = r_b;
  assign busy          = (r_state == RUN) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: behavioural registered adder with selectable faults,
// reference vector model, expected-operand queue and result table.
module tb_adder_bist;

  localparam int NV = 256;

  logic        clk = 1'b0;
  logic        rst, start, start3;
  logic [7:0]  a_o, b_o, sum_r, a3, b3, sum3_r;
  logic [1:0]  status_w, status3_w;
  logic        busy, done, pass, busy3, done3, pass3;
  logic [15:0] err_count, first_err_idx, err3, first3;
  int          fault_mode = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  m_a[NV];
  logic [7:0]  m_b[NV];

  typedef struct {
    int fault;
    bit hold;
    bit exp_pass;
    int exp_err;
    int exp_first;
  } rec_t;
  rec_t recs[4];

  always #5 clk = ~clk;

  function automatic logic [1:0] tb_cls(input logic [7:0] s);
    if (s == 8'h00)      return 2'b00;
    else if (s == 8'hFF) return 2'b01;
    else                 return 2'b10;
  endfunction

  // Behavioural adder under test, with planted faults selected by fault_mode.
  always @(posedge clk) begin
    if (rst)                  sum_r <= 8'h00;
    else if (fault_mode == 1) sum_r <= (a_o + b_o) | 8'h01;
    else                      sum_r <= a_o + b_o;
    if (rst) sum3_r <= 8'h00;
    else     sum3_r <= a3 + b3;
  end
  assign status_w  = (fault_mode == 2 && sum_r == 8'hFF) ? 2'b10 : tb_cls(sum_r);
  assign status3_w = tb_cls(sum3_r);

  adder_bist #(.WIDTH(8), .NUM_VECTORS(NV), .SEED(32'h0000_00A5)) dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o),
    .sum_i(sum_r), .status_i(status_w), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  adder_bist #(.WIDTH(8), .NUM_VECTORS(3), .SEED(32'h0000_00A5)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3),
    .sum_i(sum3_r), .status_i(status3_w), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_idx(first3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic build_model();
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < NV; i++) begin
      if (i == 0)      begin m_a[i] = 8'h00; m_b[i] = 8'h00; end
      else if (i == 1) begin m_a[i] = 8'hFF; m_b[i] = 8'h00; end
      else if (i == 2) begin m_a[i] = 8'hFF; m_b[i] = 8'h01; end
      else begin
        m_a[i] = 8'(i);
        m_b[i] = l;
        l = lfsr_step(l);
      end
    end
  endtask

  task automatic count_model(output int n_even, output int n_max);
    logic [7:0] s;
    n_even = 0;
    n_max  = 0;
    for (int i = 0; i < NV; i++) begin
      s = m_a[i] + m_b[i];
      if (s[0] == 1'b0) n_even++;
      if (s == 8'hFF)   n_max++;
    end
  endtask

  task automatic start_run(input bit hold);
    exp_q.delete();
    for (int i = 0; i < NV; i++) exp_q.push_back({m_a[i], m_b[i]});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("first_busy", busy, 1);
    check("first_done", done, 0);
    check("first_pass", pass, 0);
  endtask

  task automatic step_vector(input int i);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL exp_q_underflow: vector %0d has no expected entry", i);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d_ab", i), {a_o, b_o}, e);
    end
    @(negedge clk);
  endtask

  task automatic run_full(input rec_t rc);
    int cycles;
    fault_mode = rc.fault;
    start_run(rc.hold);
    cycles = 0;
    while (busy === 1'b1 && cycles < NV + 10) begin
      if (cycles < NV) step_vector(cycles);
      else begin
        check("drain_ab", {a_o, b_o}, 16'h0000);
        @(negedge clk);
      end
      cycles++;
    end
    start = 1'b0;
    check("busy_cycles", cycles, NV + 1);
    check("done", done, 1);
    check("pass", pass, rc.exp_pass);
    check("err_count", err_count, rc.exp_err);
    if (rc.exp_err != 0) check("first_err_idx", first_err_idx, rc.exp_first);
    check("done_ab", {a_o, b_o}, 16'h0000);
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
    check("err_hold", err_count, rc.exp_err);
    check("pass_hold", pass, rc.exp_pass);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int n_even, n_max, cycles;
    logic [15:0] corner3[3];
    build_model();
    count_model(n_even, n_max);
    recs[0] = '{fault: 0, hold: 1'b0, exp_pass: 1'b1, exp_err: 0,      exp_first: 0};
    recs[1] = '{fault: 1, hold: 1'b0, exp_pass: 1'b0, exp_err: n_even, exp_first: 0};
    recs[2] = '{fault: 2, hold: 1'b0, exp_pass: 1'b0, exp_err: n_max,  exp_first: 1};
    recs[3] = '{fault: 0, hold: 1'b1, exp_pass: 1'b1, exp_err: 0,      exp_first: 0};

    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ab", {a_o, b_o}, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 4; r++) run_full(recs[r]);

    // Abort a faulty run at index 100 and confirm nothing survives.
    fault_mode = 1;
    start_run(1'b0);
    for (int i = 0; i < 100; i++) step_vector(i);
    check("pre_abort_errs", (err_count != 16'd0), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 0);
    check("abort_ab", {a_o, b_o}, 16'h0000);
    check("abort_pass", pass, 0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_full(recs[0]);

    // Minimum-length run: only the three corner vectors.
    corner3[0] = 16'h0000;
    corner3[1] = 16'hFF00;
    corner3[2] = 16'hFF01;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(corner3[i]);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cycles = 0;
    while (busy3 === 1'b1 && cycles < 20) begin
      if (cycles < 3 && exp_q.size() != 0) check($sformatf("nv3_vec%0d", cycles), {a3, b3}, exp_q.pop_front());
      @(negedge clk);
      cycles++;
    end
    check("nv3_busy_cycles", cycles, 4);
    check("nv3_done", done3, 1);
    check("nv3_pass", pass3, 1);
    check("nv3_err", err3, 0);
    check("nv3_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
